wait_state_memory: RTL

WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

---
 rtl/wait_state_memory.sv | 104 ++++++++++
 1 files changed

// File: rtl/wait_state_memory.sv
// Word-addressed storage behind a fixed wait-state handshake: a request is latched,
// held for LATENCY cycles, then answered with a single-cycle oRdy/oErr/oData response.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no request in flight; accepts iRead/iWrite
// S_WAIT | request latched; wait counter running down to zero
// S_RESP | oRdy high for one cycle; a legal write commits on the exit edge
module wait_state_memory #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                LATENCY   = 2,
   parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
   input  logic              iClk,
   input  logic              nRst,
   input  logic [ADDR_W-1:0] iAddr,
   input  logic [DATA_W-1:0] iData,
   input  logic              iRead,
   input  logic              iWrite,
   output logic [DATA_W-1:0] oData,
   output logic              oRdy,
   output logic              oErr
);

   localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]    LAT     = 4'(LATENCY);
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                rd_q, wr_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   offset;
   logic [IDX_W-1:0]    idx;
   logic                in_range;
   logic                req_err;
   logic                accept;

   assign accept   = (state_q == S_IDLE) && (iRead || iWrite);
   assign offset   = addr_q - BASE_ADDR;
   assign idx      = offset[IDX_W-1:0];
   assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < DEPTH_A);
   assign req_err  = (rd_q && wr_q) || !in_range;

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (iRead || iWrite) state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      oRdy  = 1'b0;
      oErr  = 1'b0;
      oData = NOP_WORD;
      if (state_q == S_RESP) begin
         oRdy = 1'b1;
         oErr = req_err;
         if (rd_q && !wr_q && in_range) oData = mem[idx];
      end
   end

   // Request is captured once at acceptance; bus activity afterwards is ignored.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         cnt_q  <= 4'd0;
         addr_q <= '0;
         data_q <= '0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
      end else if (accept) begin
         cnt_q  <= LAT;
         addr_q <= iAddr;
         data_q <= iData;
         rd_q   <= iRead;
         wr_q   <= iWrite;
      end else if (state_q == S_WAIT) begin
         cnt_q  <= cnt_q - 4'd1;
      end
   end

   // Storage has no reset; a reset that cuts RESP short also cancels the write.
   always_ff @(posedge iClk) begin
      if (state_q == S_RESP && wr_q && !rd_q && in_range)
         mem[idx] <= data_q;
   end

endmodule
